// File: rtl/capsense_pkg.sv
// Shared types and helpers for the capacitive sensor scan controller.
// Scan states, default array geometry and the saturating adder.
package capsense_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HIGH,
        LOW,
        EVAL,
        REPORT
    } state_t;

    localparam int NUM_CH_DEF = 9;
    localparam int CNT_W_DEF  = 32;

    typedef logic [CNT_W_DEF-1:0] count_t;
    typedef logic [CNT_W_DEF-1:0] baseline_t;

    // a + b clamped to 2**w-1 (w <= 63)
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          w
    );
        logic [64:0] s;
        logic [64:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (s > lim) ? lim[63:0] : s[63:0];
    endfunction

endpackage

// File: rtl/capsense_debounce.sv
// One channel of touch debounce: a stable bit that flips only after
// DEBOUNCE consecutive disagreeing samples.
module capsense_debounce
    import capsense_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic sample_en,
    input  logic raw,
    output logic stable
);

    localparam int DB_W = 3;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic [DB_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sample_en) begin
            if (raw == stable) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt    <= '0;
                stable <= ~stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/capsense_scan_ctrl.sv
// Scan sequencer, baseline calibration and touch reporting for the pad array.
// Define CAPSENSE_BASELINE_TRACK_EN to let idle baselines drift toward the counts.
module capsense_scan_ctrl
    import capsense_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int HALF_PERIOD = 50000,
    parameter int THRESH      = 200,
    parameter int DEBOUNCE    = 3,
    parameter int CAL_SHIFT   = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    recal,
    input  logic [NUM_CH*CNT_W-1:0] counts,
    output logic                    sensor_trigger,
    output logic                    calibrated,
    output logic [NUM_CH-1:0]       touch_mask,
    output logic                    touch_valid,
    input  logic                    touch_ready,
    output logic                    scan_done
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PH_W  = $clog2(HALF_PERIOD + 1);
    localparam int SUM_W = CNT_W + CAL_SHIFT;
    localparam int CAL_W = CAL_SHIFT + 1;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_PERIOD - 1);
    localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'((1 << CAL_SHIFT) - 1);

    state_t            state, state_next;
    logic [PH_W-1:0]   phase;
    logic [CH_W-1:0]   ch_idx;
    logic [CAL_W-1:0]  cal_cnt;
    logic [CNT_W-1:0]  cnt_arr  [NUM_CH];
    logic [CNT_W-1:0]  baseline [NUM_CH];
    logic [SUM_W-1:0]  cal_sum  [NUM_CH];
    logic [NUM_CH-1:0] raw_reg;
    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] stable;
    logic [CNT_W-1:0]  cnt_cur;
    logic [CNT_W-1:0]  thr_cur;
    logic              raw_now;
    logic              in_eval;
    logic              in_report;
    logic              commit;
    logic              abort_cal;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign cnt_arr[k] = counts[k*CNT_W +: CNT_W];
    end

    assign sensor_trigger = (state == HIGH);
    assign scan_done      = (state == REPORT);
    assign in_eval        = (state == EVAL);
    assign in_report      = (state == REPORT) && !recal;
    assign commit         = in_eval && (ch_idx == CH_LAST) && enable && !recal;
    // An aborted calibration scan would leave partial sums, so restart it
    assign abort_cal      = in_eval && !enable && !calibrated && !recal;

    always_comb begin
        cnt_cur = cnt_arr[ch_idx];
        thr_cur = CNT_W'(sat_add(64'(baseline[ch_idx]), 64'(THRESH), CNT_W));
        raw_now = (cnt_cur > thr_cur);
        raw_vec = raw_reg;
        raw_vec[ch_idx] = raw_now;
    end

    always_comb begin
        state_next = state;
        if (recal) begin
            state_next = enable ? HIGH : IDLE;
        end else if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_next = HIGH;
                HIGH:    if (phase == PH_LAST) state_next = LOW;
                LOW:     if (phase == PH_LAST) state_next = EVAL;
                EVAL:    if (ch_idx == CH_LAST) state_next = REPORT;
                REPORT:  state_next = HIGH;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            phase  <= '0;
            ch_idx <= '0;
        end else begin
            state <= state_next;
            if (recal || state_next != state)
                phase <= '0;
            else if (state == HIGH || state == LOW)
                phase <= phase + 1'b1;
            if (in_eval && state_next == EVAL)
                ch_idx <= ch_idx + 1'b1;
            else
                ch_idx <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || recal) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cal_sum[k]  <= '0;
                baseline[k] <= '0;
            end
            cal_cnt    <= '0;
            calibrated <= 1'b0;
            raw_reg    <= '0;
        end else begin
            if (abort_cal) begin
                for (int k = 0; k < NUM_CH; k++)
                    cal_sum[k] <= '0;
                cal_cnt <= '0;
            end else if (in_eval && !calibrated) begin
                cal_sum[ch_idx] <= cal_sum[ch_idx] + SUM_W'(cnt_cur);
            end
            if (in_eval && calibrated) begin
                raw_reg[ch_idx] <= raw_now;
`ifdef CAPSENSE_BASELINE_TRACK_EN
                if (!stable[ch_idx] && !raw_now) begin
                    if (cnt_cur > baseline[ch_idx])
                        baseline[ch_idx] <= baseline[ch_idx] + 1'b1;
                    else if (cnt_cur < baseline[ch_idx])
                        baseline[ch_idx] <= baseline[ch_idx] - 1'b1;
                end
`endif
            end
            if (state == REPORT && !calibrated) begin
                if (cal_cnt == CAL_LAST) begin
                    for (int k = 0; k < NUM_CH; k++)
                        baseline[k] <= CNT_W'(cal_sum[k] >> CAL_SHIFT);
                    calibrated <= 1'b1;
                    cal_cnt    <= '0;
                end else begin
                    cal_cnt <= cal_cnt + 1'b1;
                end
            end
        end
    end

    // Debounce samples the whole scan at once on its last EVAL cycle
    for (genvar k = 0; k < NUM_CH; k++) begin : g_db
        capsense_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_db (
            .clock     (clock),
            .reset     (reset),
            .clr       (recal),
            .sample_en (commit && calibrated),
            .raw       (raw_vec[k]),
            .stable    (stable[k])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            touch_mask  <= '0;
            touch_valid <= 1'b0;
        end else if (in_report && !touch_valid && stable != touch_mask) begin
            touch_mask  <= stable;
            touch_valid <= 1'b1;
        end else if (touch_valid && touch_ready) begin
            touch_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_capsense_scan_ctrl.sv
// Directed bench for capsense_scan_ctrl with a short trigger phase
// and two-scan calibration.
module tb_capsense_scan_ctrl;

    localparam int NCH = 9;
    localparam int CW  = 32;

    logic              clock;
    logic              reset;
    logic              enable;
    logic              recal;
    logic [NCH*CW-1:0] counts;
    logic              sensor_trigger;
    logic              calibrated;
    logic [NCH-1:0]    touch_mask;
    logic              touch_valid;
    logic              touch_ready;
    logic              scan_done;

    int checks = 0;
    int errors = 0;

    capsense_scan_ctrl #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .HALF_PERIOD (4),
        .THRESH      (200),
        .DEBOUNCE    (3),
        .CAL_SHIFT   (1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .recal          (recal),
        .counts         (counts),
        .sensor_trigger (sensor_trigger),
        .calibrated     (calibrated),
        .touch_mask     (touch_mask),
        .touch_valid    (touch_valid),
        .touch_ready    (touch_ready),
        .scan_done      (scan_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_all(input logic [CW-1:0] v);
        for (int k = 0; k < NCH; k++)
            counts[k*CW +: CW] = v;
    endtask

    task automatic set_ch(input int k, input logic [CW-1:0] v);
        counts[k*CW +: CW] = v;
    endtask

    // Runs to the REPORT of the current scan, then one cycle past it
    task automatic run_scan();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clock);
            if (scan_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL scan_timeout got no scan_done exp scan_done within 40 cycles");
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [4:0] got;
        reset = 1'b1; enable = 1'b0; recal = 1'b0; touch_ready = 1'b0;
        set_all(32'd1000);
        repeat (3) @(negedge clock);
        got = {sensor_trigger, calibrated, touch_valid, scan_done, |touch_mask};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 00000", got);
        end
    endtask

    task automatic test_trigger();
        logic [35:0] tv, dv, et, ed;
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 36; i++) begin
            @(negedge clock);
            tv[i] = sensor_trigger;
            dv[i] = scan_done;
            et[i] = ((i % 18) < 4);
            ed[i] = ((i % 18) == 17);
        end
        checks++;
        if (tv !== et) begin
            errors++;
            $display("FAIL trigger_wave got %h exp %h", tv, et);
        end
        checks++;
        if (dv !== ed) begin
            errors++;
            $display("FAIL scan_done_wave got %h exp %h", dv, ed);
        end
        checks++;
        if (calibrated !== 1'b0) begin
            errors++;
            $display("FAIL cal_in_report2 got %b exp 0", calibrated);
        end
        @(negedge clock);
        checks++;
        if (calibrated !== 1'b1) begin
            errors++;
            $display("FAIL cal_after_scan2 got %b exp 1", calibrated);
        end
    endtask

    task automatic test_idle_counts();
        for (int s = 0; s < 2; s++) begin
            run_scan();
            checks++;
            if (touch_valid !== 1'b0 || calibrated !== 1'b1) begin
                errors++;
                $display("FAIL steady_scan%0d got valid=%b cal=%b exp valid=0 cal=1",
                         s, touch_valid, calibrated);
            end
        end
    endtask

    task automatic test_threshold();
        set_ch(4, 32'd1200);
        for (int s = 0; s < 4; s++) begin
            run_scan();
            checks++;
            if (touch_valid !== 1'b0) begin
                errors++;
                $display("FAIL thresh_equal_scan%0d got valid=%b exp 0", s, touch_valid);
            end
        end
        set_ch(4, 32'd1201);
        for (int s = 0; s < 3; s++) begin
            run_scan();
            checks++;
            if (touch_valid !== (s == 2)) begin
                errors++;
                $display("FAIL touch_scan%0d got valid=%b exp %b", s, touch_valid, s == 2);
            end
        end
        checks++;
        if (touch_mask !== 9'h010) begin
            errors++;
            $display("FAIL touch_mask got %h exp 010", touch_mask);
        end
    endtask

    task automatic test_backpressure();
        set_ch(4, 32'd1000);
        for (int s = 0; s < 3; s++) begin
            run_scan();
            checks++;
            if (touch_mask !== 9'h010 || touch_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold_scan%0d got mask=%h valid=%b exp mask=010 valid=1",
                         s, touch_mask, touch_valid);
            end
        end
        touch_ready = 1'b1;
        @(negedge clock);
        touch_ready = 1'b0;
        checks++;
        if (touch_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_drop got valid=%b exp 0", touch_valid);
        end
        run_scan();
        checks++;
        if (touch_mask !== 9'h000 || touch_valid !== 1'b1) begin
            errors++;
            $display("FAIL release_report got mask=%h valid=%b exp mask=000 valid=1",
                     touch_mask, touch_valid);
        end
        touch_ready = 1'b1;
        @(negedge clock);
        touch_ready = 1'b0;
        checks++;
        if (touch_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_drop2 got valid=%b exp 0", touch_valid);
        end
    endtask

    task automatic test_debounce();
        touch_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            set_ch(0, (s % 2 == 0) ? 32'd1201 : 32'd1000);
            run_scan();
            checks++;
            if (touch_valid !== 1'b0 || touch_mask !== 9'h000) begin
                errors++;
                $display("FAIL toggle_scan%0d got mask=%h valid=%b exp mask=000 valid=0",
                         s, touch_mask, touch_valid);
            end
        end
        set_ch(0, 32'd1201);
        repeat (3) run_scan();
        checks++;
        if (touch_valid !== 1'b1 || touch_mask !== 9'h001) begin
            errors++;
            $display("FAIL load_with_ready got mask=%h valid=%b exp mask=001 valid=1",
                     touch_mask, touch_valid);
        end
        @(negedge clock);
        checks++;
        if (touch_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_drop got valid=%b exp 0", touch_valid);
        end
        set_ch(0, 32'd1000);
        repeat (3) run_scan();
        checks++;
        if (touch_valid !== 1'b1 || touch_mask !== 9'h000) begin
            errors++;
            $display("FAIL ch0_release got mask=%h valid=%b exp mask=000 valid=1",
                     touch_mask, touch_valid);
        end
        @(negedge clock);
        touch_ready = 1'b0;
    endtask

    task automatic test_enable();
        logic bad;
        checks++;
        if (sensor_trigger !== 1'b1) begin
            errors++;
            $display("FAIL trig_mid_high got %b exp 1", sensor_trigger);
        end
        enable = 1'b0;
        @(negedge clock);
        checks++;
        if (sensor_trigger !== 1'b0) begin
            errors++;
            $display("FAIL trig_after_disable got %b exp 0", sensor_trigger);
        end
        bad = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (sensor_trigger !== 1'b0 || scan_done !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet got activity=%b exp 0", bad);
        end
        enable = 1'b1;
        @(negedge clock);
        checks++;
        if (sensor_trigger !== 1'b1 || calibrated !== 1'b1) begin
            errors++;
            $display("FAIL resume got trig=%b cal=%b exp trig=1 cal=1",
                     sensor_trigger, calibrated);
        end
        run_scan();
        checks++;
        if (touch_valid !== 1'b0 || calibrated !== 1'b1) begin
            errors++;
            $display("FAIL resume_scan got valid=%b cal=%b exp valid=0 cal=1",
                     touch_valid, calibrated);
        end
    endtask

    task automatic test_recal();
        set_all(32'hFFFF_FFF0);
        recal = 1'b1;
        @(negedge clock);
        recal = 1'b0;
        checks++;
        if (calibrated !== 1'b0) begin
            errors++;
            $display("FAIL recal_clear got cal=%b exp 0", calibrated);
        end
        for (int s = 0; s < 2; s++) begin
            run_scan();
            checks++;
            if (calibrated !== (s == 1)) begin
                errors++;
                $display("FAIL recal_scan%0d got cal=%b exp %b", s, calibrated, s == 1);
            end
        end
        set_all(32'hFFFF_FFFF);
        for (int s = 0; s < 4; s++) begin
            run_scan();
            checks++;
            if (touch_valid !== 1'b0 || touch_mask !== 9'h000) begin
                errors++;
                $display("FAIL sat_thresh_scan%0d got mask=%h valid=%b exp mask=000 valid=0",
                         s, touch_mask, touch_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_idle_counts();
        test_threshold();
        test_backpressure();
        test_debounce();
        test_enable();
        test_recal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
